// File: rtl/t_pass_mon_pkg.sv
// Shared types for the pass monitor: FSM state encoding and fail-code values.
// Fail codes are also consumed by the C++ harness header generator.
package t_pass_mon_pkg;

  typedef enum logic [2:0] {
    ARM   = 3'd0,
    WAIT  = 3'd1,
    CHECK = 3'd2,
    PASS  = 3'd3,
    FAIL  = 3'd4
  } state_t;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_EARLY     = 3'd1;
  localparam logic [2:0] FC_TIMEOUT   = 3'd2;
  localparam logic [2:0] FC_GLITCH    = 3'd3;
  localparam logic [2:0] FC_LATE_DROP = 3'd4;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/t_pass_mon_sync2.sv
// Two-flop synchroniser for a single level crossing into the monitor clock.
module t_pass_mon_sync2 (
  input  logic clk,
  input  logic reset_l,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/t_pass_monitor.sv
// Verdict monitor for the test top's 'passed' flag; all decisions use the synced level.
// Build option T_PASS_MON_LATE_DROP_EN: a drop of passed after PASS turns the verdict into a late-drop fail.
//
// state | meaning
// ARM   | hold-off after reset, passed must stay low
// WAIT  | waiting for passed to rise, timeout armed
// CHECK | counting consecutive high samples
// PASS  | pass verdict reached
// FAIL  | fail verdict reached, fail_code holds the reason
module t_pass_monitor
  import t_pass_mon_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int STABLE_CYCLES  = 3
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        passed,
  output logic        done,
  output logic        ok,
  output logic [2:0]  fail_code,
  output logic [31:0] cycles
);

  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_N  = SW'(STABLE_CYCLES);
  localparam logic [31:0]   TIMEOUT   = 32'(TIMEOUT_CYCLES);

  logic          ps;
  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] stable_cnt;
  logic          timeout_hit;

  t_pass_mon_sync2 u_sync (
    .clk     (clk),
    .reset_l (reset_l),
    .d       (passed),
    .q       (ps)
  );

  // A rise on the timeout clock wins, so the timeout only fires with ps low.
  assign timeout_hit = (state == WAIT) && !ps && (cycles == TIMEOUT);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state      <= ARM;
      hold_cnt   <= '0;
      stable_cnt <= '0;
      done       <= 1'b0;
      ok         <= 1'b0;
      fail_code  <= FC_NONE;
      cycles     <= '0;
    end else begin
      if ((state == WAIT || state == CHECK) && !timeout_hit)
        cycles <= sat_inc(cycles);

      case (state)
        ARM: begin
          if (ps) begin
            state     <= FAIL;
            done      <= 1'b1;
            fail_code <= FC_EARLY;
          end else if (hold_cnt == HOLD_LAST) begin
            state <= WAIT;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        WAIT: begin
          if (ps) begin
            state      <= CHECK;
            stable_cnt <= SW'(1);
          end else if (timeout_hit) begin
            state     <= FAIL;
            done      <= 1'b1;
            fail_code <= FC_TIMEOUT;
          end
        end
        CHECK: begin
          if (!ps) begin
            state     <= FAIL;
            done      <= 1'b1;
            fail_code <= FC_GLITCH;
          end else if (stable_cnt == STABLE_N) begin
            state <= PASS;
            done  <= 1'b1;
            ok    <= 1'b1;
          end else begin
            stable_cnt <= stable_cnt + SW'(1);
          end
        end
        PASS: begin
`ifdef T_PASS_MON_LATE_DROP_EN
          if (!ps) begin
            state     <= FAIL;
            ok        <= 1'b0;
            fail_code <= FC_LATE_DROP;
          end
`endif
        end
        FAIL: begin
        end
        default: state <= ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_t_pass_monitor.sv
// Bench for t_pass_monitor: three parameterisations share one passed trace, checked each clk against a trace model.
module tb_t_pass_monitor;

  localparam int H_A = 4, T_A = 20,   S_A = 3;
  localparam int H_B = 4, T_B = 1000, S_B = 3;
  localparam int H_C = 2, T_C = 30,   S_C = 1;

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  logic passed = 1'b0;

  logic        done_w [3];
  logic        ok_w   [3];
  logic [2:0]  fc_w   [3];
  logic [31:0] cyc_w  [3];

  int hp [3] = '{H_A, H_B, H_C};
  int tp [3] = '{T_A, T_B, T_C};
  int sp [3] = '{S_A, S_B, S_C};

  bit p_hist [0:1023];
  int n_edges = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  t_pass_monitor #(.HOLDOFF_CYCLES(H_A), .TIMEOUT_CYCLES(T_A), .STABLE_CYCLES(S_A)) u_a (
    .clk(clk), .reset_l(reset_l), .passed(passed),
    .done(done_w[0]), .ok(ok_w[0]), .fail_code(fc_w[0]), .cycles(cyc_w[0]));
  t_pass_monitor #(.HOLDOFF_CYCLES(H_B), .TIMEOUT_CYCLES(T_B), .STABLE_CYCLES(S_B)) u_b (
    .clk(clk), .reset_l(reset_l), .passed(passed),
    .done(done_w[1]), .ok(ok_w[1]), .fail_code(fc_w[1]), .cycles(cyc_w[1]));
  t_pass_monitor #(.HOLDOFF_CYCLES(H_C), .TIMEOUT_CYCLES(T_C), .STABLE_CYCLES(S_C)) u_c (
    .clk(clk), .reset_l(reset_l), .passed(passed),
    .done(done_w[2]), .ok(ok_w[2]), .fail_code(fc_w[2]), .cycles(cyc_w[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Synced level seen by the monitor at edge e: the input sampled two edges earlier.
  function automatic bit psv(input int e);
    return (e >= 3) ? p_hist[e-2] : 1'b0;
  endfunction

  // Verdict after n edges, derived from the passed trace and the monitor rules.
  function automatic void model(input int n, input int h, input int t, input int s,
                                output bit d, output bit o, output int fc, output int cy);
    int rise;
    int w;
    d = 0; o = 0; fc = 0; cy = 0;
    for (int e = 1; e <= h && e <= n; e++)
      if (psv(e)) begin d = 1; fc = 1; return; end
    if (n <= h) return;
    rise = 0;
    for (int j = 1; j <= t + 1 && h + j <= n; j++)
      if (psv(h + j)) begin rise = j; break; end
    if (rise == 0) begin
      if (n >= h + t + 1) begin d = 1; fc = 2; cy = t; end
      else cy = n - h;
      return;
    end
    w = h + rise;
    for (int k = 1; k <= s; k++) begin
      if (w + k > n) begin cy = rise + (n - w); return; end
      if (!psv(w + k)) begin d = 1; fc = 3; cy = rise + k; return; end
    end
    d = 1; o = 1; cy = rise + s;
`ifdef T_PASS_MON_LATE_DROP_EN
    for (int e = w + s + 1; e <= n; e++)
      if (!psv(e)) begin o = 0; fc = 4; return; end
`endif
  endfunction

  task automatic check_all(input string scen);
    bit d, o;
    int fc, cy;
    for (int i = 0; i < 3; i++) begin
      model(n_edges, hp[i], tp[i], sp[i], d, o, fc, cy);
      check($sformatf("%s/u%0d/e%0d/done", scen, i, n_edges), 32'(done_w[i]), 32'(d));
      check($sformatf("%s/u%0d/e%0d/ok", scen, i, n_edges), 32'(ok_w[i]), 32'(o));
      check($sformatf("%s/u%0d/e%0d/fail_code", scen, i, n_edges), 32'(fc_w[i]), 32'(fc));
      check($sformatf("%s/u%0d/e%0d/cycles", scen, i, n_edges), cyc_w[i], 32'(cy));
    end
  endtask

  task automatic check_zero(input string scen);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s/u%0d/rst_done", scen, i), 32'(done_w[i]), 32'd0);
      check($sformatf("%s/u%0d/rst_ok", scen, i), 32'(ok_w[i]), 32'd0);
      check($sformatf("%s/u%0d/rst_fc", scen, i), 32'(fc_w[i]), 32'd0);
      check($sformatf("%s/u%0d/rst_cycles", scen, i), cyc_w[i], 32'd0);
    end
  endtask

  task automatic tick(input string scen);
    bit v;
    v = passed;
    @(posedge clk);
    if (n_edges < 1023) n_edges++;
    p_hist[n_edges] = v;
    #1;
    check_all(scen);
  endtask

  task automatic do_reset(input string scen);
    reset_l = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero(scen);
    @(negedge clk);
    reset_l = 1'b1;
    n_edges = 0;
  endtask

  // passed is high on edges r .. r+len-1 (counted from reset release).
  task automatic drive(input string scen, input int r, input int len, input int upto);
    while (n_edges < upto) begin
      passed = (n_edges + 1 >= r) && (n_edges + 1 < r + len);
      tick(scen);
    end
  endtask

  initial begin
    int r, len;
    int lens [6] = '{1, 2, 3, 4, 6, 1000};

    // 1: rise at clk 10, stays high
    passed = 1'b0;
    do_reset("s1");
    drive("s1", 10, 1000, 14);
    check("s1/done_before", 32'(done_w[1]), 32'd0);
    drive("s1", 10, 1000, 15);
    check("s1/done_at_15", 32'(done_w[1]), 32'd1);
    drive("s1", 10, 1000, 30);
    check("s1/ok", 32'(ok_w[1]), 32'd1);
    check("s1/fail_code", 32'(fc_w[1]), 32'd0);

    // 2: passed high through reset and after
    passed = 1'b1;
    do_reset("s2");
    drive("s2", 1, 1000, 6);
    check("s2/done", 32'(done_w[0]), 32'd1);
    check("s2/fail_code", 32'(fc_w[0]), 32'd1);

    // 3: passed never rises
    passed = 1'b0;
    do_reset("s3");
    drive("s3", 1000, 1, H_A + T_A + 1);
    check("s3/fail_code", 32'(fc_w[0]), 32'd2);
    check("s3/cycles", cyc_w[0], 32'd20);
    drive("s3", 1000, 1, H_A + T_A + 51);
    check("s3/cycles_frozen", cyc_w[0], 32'd20);
    check("s3/done", 32'(done_w[0]), 32'd1);

    // 4a: two-clock glitch
    do_reset("s4a");
    drive("s4a", 10, 2, 30);
    check("s4a/fail_code", 32'(fc_w[0]), 32'd3);
    check("s4a/ok", 32'(ok_w[0]), 32'd0);

    // 4b: rise lands exactly on the timeout clock
    do_reset("s4b");
    drive("s4b", H_A + T_A - 1, 1000, H_A + T_A + 1);
    check("s4b/tie_not_done", 32'(done_w[0]), 32'd0);
    drive("s4b", H_A + T_A - 1, 1000, 40);
    check("s4b/tie_ok", 32'(ok_w[0]), 32'd1);

    // 5: pass, then drop
    do_reset("s5");
    drive("s5", 10, 15, 40);
    check("s5/done", 32'(done_w[1]), 32'd1);
`ifdef T_PASS_MON_LATE_DROP_EN
    check("s5/fail_code", 32'(fc_w[1]), 32'd4);
    check("s5/ok", 32'(ok_w[1]), 32'd0);
`else
    check("s5/fail_code", 32'(fc_w[1]), 32'd0);
    check("s5/ok", 32'(ok_w[1]), 32'd1);
`endif

    // 6: asynchronous reset mid-CHECK, then scenario 1 again
    do_reset("s6");
    drive("s6", 10, 1000, 13);
    #2;
    reset_l = 1'b0;
    #1;
    check_zero("s6_async");
    do_reset("s6r");
    drive("s6r", 10, 1000, 14);
    check("s6r/done_before", 32'(done_w[1]), 32'd0);
    drive("s6r", 10, 1000, 20);
    check("s6r/ok", 32'(ok_w[1]), 32'd1);
    check("s6r/cycles", cyc_w[1], 32'd11);

    // randomized pulse positions and widths
    for (int it = 0; it < 14; it++) begin
      r   = int'($urandom_range(1, 40));
      len = lens[$urandom_range(0, 5)];
      passed = 1'(($urandom_range(0, 3) == 0) && r <= 2);
      do_reset($sformatf("rnd%0d", it));
      drive($sformatf("rnd%0d_r%0d_l%0d", it, r, len), r, len, 64);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
